// File: rtl/fwd_pkg.sv
// Types and helpers for the decode-stage forwarder and long-latency scoreboard.
package fwd_pkg;

  localparam logic [4:0]  REG_X0        = 5'd0;
  localparam int unsigned NUM_ARCH_REGS = 32;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } lat_wb_t;

  // x0 is hardwired zero, so it never matches anything.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != REG_X0);
  endfunction

endpackage

// File: rtl/pipe_regs.sv
// Shared pipeline-register types used across the core.
package pipe_regs;

  // Per-stage forward source: result that will be written to the regfile.
  typedef struct packed {
    logic        valid;
    logic        rf_wr_en;
    logic        mem_read;
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } data_fwd_t;

endpackage

// File: rtl/fwd_mux.sv
// One operand port: youngest pipeline hit wins, then completing long op, then regfile.
module fwd_mux
  import pipe_regs::*;
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  data_fwd_t [NUM_FWD-1:0] fwd_i,
  input  logic [4:0]              rs_i,
  input  logic                    rs_used_i,
  input  logic [31:0]             rs_data_i,
  input  lat_wb_t                 lat_wb_i,
  output logic [31:0]             data_o,
  output logic                    hit_o,
  output logic [IDX_W-1:0]        hit_idx_o
);

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    if (rs_used_i && lat_wb_i.valid && reg_match(rs_i, lat_wb_i.rd)) begin
      data_o = lat_wb_i.data;
    end else begin
      data_o = rs_data_i;
    end
    // Walk oldest to youngest so the youngest hit overrides.
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (rs_used_i && fwd_i[k].valid && fwd_i[k].rf_wr_en && reg_match(rs_i, fwd_i[k].rd)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(k);
        data_o    = fwd_i[k].rd_data;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding, load-use detection and long-latency write scoreboard.
module fwd_hazard_unit
  import pipe_regs::*;
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_RS      = 2,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned LU_STAGES   = 1,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  data_fwd_t [NUM_FWD-1:0]      fwd_i,
  input  logic [NUM_RS-1:0][4:0]       rs_i,
  input  logic [NUM_RS-1:0][31:0]      rs_data_i,
  input  logic [NUM_RS-1:0]            rs_used_i,
  input  logic [4:0]                   rd_i,
  input  logic                         rd_wr_i,
  input  logic                         lat_issue_valid_i,
  input  logic [4:0]                   lat_issue_rd_i,
  output logic                         lat_issue_ready_o,
  input  logic                         lat_wb_valid_i,
  input  logic [4:0]                   lat_wb_rd_i,
  input  logic [31:0]                  lat_wb_data_i,
  output logic [NUM_RS-1:0][31:0]      rs_data_ao,
  output logic                         load_use_hazard_ao,
  output logic                         stall_ao,
  output logic [PEND_W-1:0]            pending_cnt_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int unsigned IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d, busy_wb;
  logic [PEND_W-1:0]        pend_q, pend_d;
  logic [CNT_W-1:0]         stall_cnt_q;

  lat_wb_t                      lat_wb;
  logic [NUM_RS-1:0]            fwd_hit;
  logic [NUM_RS-1:0][IDX_W-1:0] hit_idx;
  logic [NUM_RS-1:0]            sb_raw;
  logic                         sb_waw;
  logic                         wb_eff, issue_acc, pend_inc, pend_dec;

  assign lat_wb = '{valid: lat_wb_valid_i, rd: lat_wb_rd_i, data: lat_wb_data_i};

  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    fwd_mux #(
      .NUM_FWD (NUM_FWD),
      .IDX_W   (IDX_W)
    ) u_fwd_mux (
      .fwd_i     (fwd_i),
      .rs_i      (rs_i[p]),
      .rs_used_i (rs_used_i[p]),
      .rs_data_i (rs_data_i[p]),
      .lat_wb_i  (lat_wb),
      .data_o    (rs_data_ao[p]),
      .hit_o     (fwd_hit[p]),
      .hit_idx_o (hit_idx[p])
    );
  end

  // Only the selected (youngest) hit can cause load-use; older loads have already returned.
  always_comb begin
    load_use_hazard_ao = 1'b0;
    for (int p = 0; p < int'(NUM_RS); p++) begin
      if (fwd_hit[p] && (int'(hit_idx[p]) < int'(LU_STAGES)) && fwd_i[hit_idx[p]].mem_read) begin
        load_use_hazard_ao = 1'b1;
      end
    end
  end

  // A register completing this cycle is forwarded, so it no longer blocks.
  always_comb begin
    for (int p = 0; p < int'(NUM_RS); p++) begin
      sb_raw[p] = rs_used_i[p] && (rs_i[p] != REG_X0) && busy_q[rs_i[p]] &&
                  !(lat_wb_valid_i && (lat_wb_rd_i == rs_i[p]));
    end
    sb_waw = rd_wr_i && (rd_i != REG_X0) && busy_q[rd_i] &&
             !(lat_wb_valid_i && (lat_wb_rd_i == rd_i));
  end

  assign stall_ao          = load_use_hazard_ao || (|sb_raw) || sb_waw;
  assign lat_issue_ready_o = (pend_q < PEND_W'(MAX_PENDING));

  // Writeback clears first, then issue sets, so issue+wb to one register keeps it busy.
  always_comb begin
    wb_eff    = lat_wb_valid_i && (lat_wb_rd_i != REG_X0) && busy_q[lat_wb_rd_i];
    issue_acc = lat_issue_valid_i && lat_issue_ready_o && !stall_ao &&
                (lat_issue_rd_i != REG_X0);

    busy_wb = busy_q;
    if (wb_eff) begin
      busy_wb[lat_wb_rd_i] = 1'b0;
    end
    busy_d = busy_wb;
    if (issue_acc) begin
      busy_d[lat_issue_rd_i] = 1'b1;
    end
    busy_d[REG_X0] = 1'b0;

    pend_inc = issue_acc && !busy_wb[lat_issue_rd_i];
    pend_dec = wb_eff;
    case ({pend_inc, pend_dec})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      busy_q      <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      if (stall_ao && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign pending_cnt_o = pend_q;
  assign stall_cnt_o   = stall_cnt_q;

  issue_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (lat_issue_valid_i && (lat_issue_rd_i != REG_X0) && !stall_ao) |-> lat_issue_ready_o)
    else $warning("long-op issue to x%0d dropped: scoreboard full", lat_issue_rd_i);

  wb_not_busy: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (lat_wb_valid_i && (lat_wb_rd_i != REG_X0)) |-> busy_q[lat_wb_rd_i])
    else $error("long-op writeback to x%0d which is not busy", lat_wb_rd_i);

  pend_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    pend_q <= PEND_W'(MAX_PENDING))
    else $error("pending count above limit");

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard-driven bench for fwd_hazard_unit with default parameters.
module tb_fwd_hazard_unit;
  import pipe_regs::*;

  typedef struct packed {
    data_fwd_t   f0;
    data_fwd_t   f1;
    logic [4:0]  rs0;
    logic        u0;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rd;
    logic        rdw;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        es;
    logic        elu;
    logic        erdy;
    logic [2:0]  epend;
  } vec_t;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        stall;
    logic        lu;
    logic        rdy;
    logic [2:0]  pend;
    logic [15:0] scnt;
  } obs_t;

  logic                  clk_i = 1'b0;
  logic                  rstn_i;
  data_fwd_t [1:0]       fwd_i;
  logic [1:0][4:0]       rs_i;
  logic [1:0][31:0]      rs_data_i;
  logic [1:0]            rs_used_i;
  logic [4:0]            rd_i;
  logic                  rd_wr_i;
  logic                  lat_issue_valid_i;
  logic [4:0]            lat_issue_rd_i;
  logic                  lat_issue_ready_o;
  logic                  lat_wb_valid_i;
  logic [4:0]            lat_wb_rd_i;
  logic [31:0]           lat_wb_data_i;
  logic [1:0][31:0]      rs_data_ao;
  logic                  load_use_hazard_ao;
  logic                  stall_ao;
  logic [2:0]            pending_cnt_o;
  logic [15:0]           stall_cnt_o;

  int          checks = 0;
  int          failures = 0;
  int          exp_scnt = 0;
  logic [31:0] r0, r1;
  vec_t        tbl[$];
  obs_t        exp_q[$];
  obs_t        e, o;
  data_fwd_t   z = '0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit u_dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .fwd_i              (fwd_i),
    .rs_i               (rs_i),
    .rs_data_i          (rs_data_i),
    .rs_used_i          (rs_used_i),
    .rd_i               (rd_i),
    .rd_wr_i            (rd_wr_i),
    .lat_issue_valid_i  (lat_issue_valid_i),
    .lat_issue_rd_i     (lat_issue_rd_i),
    .lat_issue_ready_o  (lat_issue_ready_o),
    .lat_wb_valid_i     (lat_wb_valid_i),
    .lat_wb_rd_i        (lat_wb_rd_i),
    .lat_wb_data_i      (lat_wb_data_i),
    .rs_data_ao         (rs_data_ao),
    .load_use_hazard_ao (load_use_hazard_ao),
    .stall_ao           (stall_ao),
    .pending_cnt_o      (pending_cnt_o),
    .stall_cnt_o        (stall_cnt_o)
  );

  function automatic data_fwd_t fw(input logic v, input logic w, input logic m,
                                   input logic [4:0] rd, input logic [31:0] d);
    return '{valid: v, rf_wr_en: w, mem_read: m, rd: rd, rd_data: d};
  endfunction

  function automatic vec_t mkv(input data_fwd_t f0, input data_fwd_t f1,
      input logic [4:0] rs0, input logic u0, input logic [4:0] rs1, input logic u1,
      input logic [4:0] rd, input logic rdw, input logic iv, input logic [4:0] ird,
      input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
      input logic [31:0] ed0, input logic [31:0] ed1,
      input logic es, input logic elu, input logic erdy, input logic [2:0] epend);
    return '{f0, f1, rs0, u0, rs1, u1, rd, rdw, iv, ird, wv, wrd, wd,
             ed0, ed1, es, elu, erdy, epend};
  endfunction

  task automatic drive(input vec_t v);
    fwd_i[0]          = v.f0;
    fwd_i[1]          = v.f1;
    rs_i[0]           = v.rs0;
    rs_used_i[0]      = v.u0;
    rs_i[1]           = v.rs1;
    rs_used_i[1]      = v.u1;
    rs_data_i[0]      = r0;
    rs_data_i[1]      = r1;
    rd_i              = v.rd;
    rd_wr_i           = v.rdw;
    lat_issue_valid_i = v.iv;
    lat_issue_rd_i    = v.ird;
    lat_wb_valid_i    = v.wv;
    lat_wb_rd_i       = v.wrd;
    lat_wb_data_i     = v.wd;
  endtask

  function automatic obs_t sample();
    return '{rs_data_ao[0], rs_data_ao[1], stall_ao, load_use_hazard_ao,
             lat_issue_ready_o, pending_cnt_o, stall_cnt_o};
  endfunction

  // Advance past the active edge and account for a stalled cycle in the counter model.
  task automatic next_cycle(input logic stalled);
    @(posedge clk_i);
    #1;
    if (stalled && exp_scnt < 65535) exp_scnt++;
  endtask

  task automatic test_reset();
    drive(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i   = 1'b1;
    exp_scnt = 0;
    for (int i = 0; i < 4; i++) begin
      r0 = $urandom();
      r1 = $urandom();
      drive(mkv(z, z, 5'($urandom_range(1, 31)), 1, 5'($urandom_range(0, 31)), 1,
                0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
      exp_q.push_back('{r0, r1, 1'b0, 1'b0, 1'b1, 3'd0, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", i, o, e);
      end
      next_cycle(e.stall);
    end
  endtask

  task automatic test_forward();
    data_fwd_t a, b;
    a  = fw(1, 1, 0, 5, 32'hAAAA);
    b  = fw(1, 1, 0, 5, 32'hBBBB);
    r0 = $urandom();
    r1 = $urandom();
    tbl.delete();
    tbl.push_back(mkv(a, b, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA, 32'hAAAA, 0, 0, 1, 0));
    tbl.push_back(mkv(fw(1, 1, 1, 5, 32'hAAAA), b, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,
                      32'hAAAA, 32'hAAAA, 1, 1, 1, 0));
    tbl.push_back(mkv(fw(1, 1, 0, 6, 32'hAAAA), fw(1, 1, 1, 5, 32'hBBBB), 5, 1, 6, 1,
                      0, 0, 0, 0, 0, 0, 0, 32'hBBBB, 32'hAAAA, 0, 0, 1, 0));
    tbl.push_back(mkv(fw(1, 0, 1, 5, 32'hAAAA), b, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      32'hBBBB, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(fw(1, 1, 1, 5, 32'hAAAA), b, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0,
                      r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(fw(1, 1, 1, 0, 32'hAAAA), z, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                      r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(fw(0, 1, 1, 5, 32'hAAAA), z, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      r0, r1, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back('{tbl[i].ed0, tbl[i].ed1, tbl[i].es, tbl[i].elu, tbl[i].erdy,
                        tbl[i].epend, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL forward[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", i, o, e);
      end
      next_cycle(e.stall);
    end
  endtask

  task automatic test_scoreboard();
    r0 = $urandom();
    r1 = $urandom();
    tbl.delete();
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 1, 0, 1, 1));
    tbl.push_back(mkv(z, z, 7, 1, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 32'h1234, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, r0, r1, 1, 0, 1, 1));
    tbl.push_back(mkv(fw(1, 1, 0, 7, 32'hCCCC), z, 7, 1, 0, 0, 7, 1, 0, 0, 1, 7, 32'h5555,
                      32'hCCCC, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 12, 1, 0, 0, 0, 0, 1, 13, 0, 0, 0, r0, r1, 1, 0, 1, 1));
    tbl.push_back(mkv(z, z, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, r0, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back('{tbl[i].ed0, tbl[i].ed1, tbl[i].es, tbl[i].elu, tbl[i].erdy,
                        tbl[i].epend, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL scoreboard[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", i, o, e);
      end
      next_cycle(e.stall);
    end
  endtask

  task automatic test_full();
    r0 = $urandom();
    r1 = $urandom();
    tbl.delete();
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, r0, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, r0, r1, 0, 0, 1, 2));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, r0, r1, 0, 0, 1, 3));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, r0, r1, 0, 0, 0, 4));
    tbl.push_back(mkv(z, z, 10, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, r0, r1, 0, 0, 0, 4));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, r0, r1, 0, 0, 1, 3));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, r0, r1, 0, 0, 1, 2));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, r0, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back('{tbl[i].ed0, tbl[i].ed1, tbl[i].es, tbl[i].elu, tbl[i].erdy,
                        tbl[i].epend, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL full[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", i, o, e);
      end
      next_cycle(e.stall);
    end
  endtask

  task automatic test_back_to_back();
    r0 = $urandom();
    r1 = $urandom();
    tbl.delete();
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 9, 1, 0, 0, 9, 1, 1, 9, 1, 9, 32'h77, 32'h77, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 1, 0, 1, 1));
    tbl.push_back(mkv(z, z, 9, 1, 0, 0, 0, 0, 0, 0, 1, 9, 32'h88, 32'h88, r1, 0, 0, 1, 1));
    tbl.push_back(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    tbl.push_back(mkv(z, z, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 32'h99, r0, r1, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back('{tbl[i].ed0, tbl[i].ed1, tbl[i].es, tbl[i].elu, tbl[i].erdy,
                        tbl[i].epend, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)",
                 i, o, e);
      end
      next_cycle(e.stall);
    end
  endtask

  task automatic test_stall_saturation();
    r0 = $urandom();
    r1 = $urandom();
    drive(mkv(z, z, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    next_cycle(1'b0);
    drive(mkv(z, z, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 1, 0, 1, 1));
    repeat (70000) @(posedge clk_i);
    exp_scnt = (exp_scnt + 70000 > 65535) ? 65535 : exp_scnt + 70000;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{r0, r1, 1'b1, 1'b0, 1'b1, 3'd1, 16'(exp_scnt)});
      @(negedge clk_i);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall_sat[%0d]: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", i, o, e);
      end
      next_cycle(e.stall);
    end
    drive(mkv(z, z, 11, 1, 0, 0, 0, 0, 0, 0, 1, 11, 32'h4321, 32'h4321, r1, 0, 0, 1, 1));
    next_cycle(1'b0);
    drive(mkv(z, z, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 1, 0));
    exp_q.push_back('{r0, r1, 1'b0, 1'b0, 1'b1, 3'd0, 16'(exp_scnt)});
    @(negedge clk_i);
    e = exp_q.pop_front();
    o = sample();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL stall_sat_clear: got %h want %h (d0,d1,stall,lu,rdy,pend,scnt)", o, e);
    end
    next_cycle(e.stall);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_scoreboard();
    test_full();
    test_back_to_back();
    test_stall_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
